// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU/accumulator sequencer: instruction codes, ALU opcodes,
// FSM states and the decoded control bundle.
package alu_seq_pkg;

  localparam logic [3:0] I_NOP   = 4'h0;
  localparam logic [3:0] I_LIT   = 4'h1;
  localparam logic [3:0] I_ADDI  = 4'h2;
  localparam logic [3:0] I_CMPI  = 4'h3;
  localparam logic [3:0] I_NANDI = 4'h4;
  localparam logic [3:0] I_IN    = 4'h5;
  localparam logic [3:0] I_OUT   = 4'h6;
  localparam logic [3:0] I_JMP   = 4'h7;
  localparam logic [3:0] I_JC    = 4'h8;
  localparam logic [3:0] I_JNC   = 4'h9;
  localparam logic [3:0] I_JZ    = 4'hA;
  localparam logic [3:0] I_JNZ   = 4'hB;
  localparam logic [3:0] I_HALT  = 4'hF;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_PASSB = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_NAND  = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_JUMP   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic       imm_oe;
    logic       in_oe;
    logic       in_ack;
    logic       en_accu;
    logic       en_out;
    logic       upd_flags;
  } ctrl_t;

  function automatic logic is_jump(input logic [3:0] instr);
    return instr inside {I_JMP, I_JC, I_JNC, I_JZ, I_JNZ};
  endfunction

  function automatic logic jump_taken(input logic [3:0] instr, input logic c, input logic z);
    case (instr)
      I_JMP:   return 1'b1;
      I_JC:    return c;
      I_JNC:   return !c;
      I_JZ:    return z;
      I_JNZ:   return !z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_pc.sv
// Program counter for alu_sequencer: load has priority over increment; the increment
// wraps naturally modulo 2^PC_W.
module seq_pc #(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_pc <= '0;
    else if (i_load) r_pc <= i_target;
    else if (i_inc)  r_pc <= r_pc + PC_W'(1);
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/alu_sequencer.sv
// Control unit for the 4-bit ALU/accumulator datapath: fetches from a synchronous ROM,
// decodes, drives datapath enables and latches Carry/Zero for conditional jumps.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  output logic [3:0]      imm,
  output logic            imm_oe,
  output logic            in_oe,
  input  logic            in_valid,
  output logic            in_ack,
  output logic [2:0]      alu_opcode,
  output logic            en_accu,
  output logic            en_out,
  input  logic            carry_in,
  input  logic            zero_in,
  output logic            c_flag,
  output logic            z_flag,
  output logic            halted
);

  state_t          r_state;
  logic [7:0]      r_ir;
  logic            r_c;
  logic            r_z;
  logic [3:0]      w_instr;
  logic [PC_W-1:0] w_pc;
  logic [PC_W-1:0] w_target;
  logic            w_taken;
  logic            w_pc_inc;
  logic            w_pc_load;
  ctrl_t           w_ctrl;

  assign w_instr  = r_ir[7:4];
  assign w_target = PC_W'({r_ir[3:0], prog_data});
  assign w_taken  = jump_taken(w_instr, r_c, r_z);

  // Controls depend only on state, ir and in_valid, so an async reset of the state
  // clears them immediately.
  always_comb begin
    // NOTE: default every field first so no path through the case can infer a latch.
    w_ctrl = '0;
    if (r_state == S_EXEC) begin
      case (w_instr)
        I_NOP: ;
        I_LIT:   begin w_ctrl.opcode = OP_PASSB; w_ctrl.imm_oe = 1'b1; w_ctrl.en_accu = 1'b1; w_ctrl.upd_flags = 1'b1; end
        I_ADDI:  begin w_ctrl.opcode = OP_ADD;   w_ctrl.imm_oe = 1'b1; w_ctrl.en_accu = 1'b1; w_ctrl.upd_flags = 1'b1; end
        I_CMPI:  begin w_ctrl.opcode = OP_SUB;   w_ctrl.imm_oe = 1'b1; w_ctrl.upd_flags = 1'b1; end
        I_NANDI: begin w_ctrl.opcode = OP_NAND;  w_ctrl.imm_oe = 1'b1; w_ctrl.en_accu = 1'b1; w_ctrl.upd_flags = 1'b1; end
        I_IN: begin
          w_ctrl.opcode    = OP_PASSB;
          w_ctrl.in_oe     = 1'b1;
          w_ctrl.en_accu   = in_valid;
          w_ctrl.in_ack    = in_valid;
          w_ctrl.upd_flags = in_valid;
        end
        I_OUT:   begin w_ctrl.opcode = OP_PASSA; w_ctrl.en_out = 1'b1; end
        I_JMP, I_JC, I_JNC, I_JZ, I_JNZ, I_HALT: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (run) r_state <= S_DECODE;
        S_DECODE: begin
          r_ir    <= prog_data;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_ctrl.upd_flags) begin
            r_c <= carry_in;
            r_z <= zero_in;
          end
          if (w_instr == I_IN && !in_valid) r_state <= S_EXEC;
          else if (is_jump(w_instr))        r_state <= S_JUMP;
          else if (w_instr == I_HALT)       r_state <= S_HALT;
          else                              r_state <= S_FETCH;
        end
        S_JUMP:  r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // The jump operand byte is fetched from pc during EXEC and arrives in JUMP.
  assign w_pc_inc  = (r_state == S_DECODE) || (r_state == S_JUMP && !w_taken);
  assign w_pc_load = (r_state == S_JUMP) && w_taken;

  seq_pc #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_pc_inc),
    .i_load   (w_pc_load),
    .i_target (w_target),
    .o_pc     (w_pc)
  );

  assign prog_addr  = w_pc;
  assign imm        = r_ir[3:0];
  assign imm_oe     = w_ctrl.imm_oe;
  assign in_oe      = w_ctrl.in_oe;
  assign in_ack     = w_ctrl.in_ack;
  assign alu_opcode = w_ctrl.opcode;
  assign en_accu    = w_ctrl.en_accu;
  assign en_out     = w_ctrl.en_out;
  assign c_flag     = r_c;
  assign z_flag     = r_z;
  assign halted     = (r_state == S_HALT);

endmodule
